// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory port arbiter.
// Index math is sized for the largest supported requester count (8).
package dmem_arb_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;
  localparam int unsigned MAX_REQ   = 8;
  localparam int unsigned IDX_W     = 3;

  typedef logic [MAX_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0]   req_idx_t;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic     valid;
    req_idx_t idx;
  } rd_tag_t;

  function automatic req_idx_t onehot2idx(input req_vec_t oh);
    req_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  // First requester at or after ptr, wrapping modulo n; one-hot result.
  function automatic req_vec_t rr_pick(input req_vec_t req, input req_idx_t ptr,
                                       input int unsigned n);
    req_vec_t    g;
    int unsigned j;
    g = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      j = 32'(ptr) + i;
      if (j >= n) j = j - n;
      if ((i < n) && (g == '0) && req[j[IDX_W-1:0]]) g[j[IDX_W-1:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side and RAM-side signals of one arbitrated data-memory port.
interface dmem_port_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    rvalid;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_ren;
  logic                mem_wren;
  logic [DW-1:0]       mem_q;

  modport slave (
    input  req, req_wr, req_lock, req_addr, req_wdata, mem_q,
    output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_ren, mem_wren
  );

  modport master (
    output req, req_wr, req_lock, req_addr, req_wdata, mem_q,
    input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_ren, mem_wren
  );
endinterface

// File: rtl/dmem_rd_tag_pipe.sv
// RD_LAT-deep shift register of read tags {valid, requester index}.
// tag_next_c is the tag about to enter the last stage, used to time rdata capture.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_next_c,
  output rd_tag_t tag_out
);

  rd_tag_t stage_q [RD_LAT];
  rd_tag_t stage_d [RD_LAT];

  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < RD_LAT; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LAT; i++) stage_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RD_LAT; i++) stage_q[i] <= stage_d[i];
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign tag_next_c = tag_in;
    end else begin : g_latn
      assign tag_next_c = stage_q[RD_LAT-2];
    end
  endgenerate

  assign tag_out = stage_q[RD_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// N-requester arbiter for one shared data-memory RAM port: fixed-priority or
// round-robin grant, burst locking, and tagged read return to the issuer.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N_REQ    = 3,
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ARB_MODE = ARB_FIXED
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);

  lock_state_e   state_q, state_d;
  req_idx_t      lock_owner_q, lock_owner_d;
  req_idx_t      rr_ptr_q, rr_ptr_d;
  logic [DW-1:0] rdata_q, rdata_d;

  req_vec_t req_v, wr_v, lock_v, pick;
  req_idx_t gnt_idx;
  logic     any_gnt, lock_eff, lock_sel;
  rd_tag_t  tag_in, tag_next, tag_out;

  assign req_v  = MAX_REQ'(bus.req);
  assign wr_v   = MAX_REQ'(bus.req_wr);
  assign lock_v = MAX_REQ'(bus.req_lock);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      lock_owner_q <= '0;
      rr_ptr_q     <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      rdata_q      <= rdata_d;
    end
  end

  // Grant selection and RAM mux; an out-of-range owner is treated as unlocked.
  always_comb begin
    pick          = '0;
    bus.gnt       = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_wren  = 1'b0;
    lock_eff      = (state_q == ST_LOCKED) && (32'(lock_owner_q) < N_REQ) &&
                    req_v[lock_owner_q];
    if (!rst) begin
      if (lock_eff) pick[lock_owner_q] = 1'b1;
      else pick = rr_pick(req_v, (ARB_MODE == ARB_RR) ? rr_ptr_q : req_idx_t'(0), N_REQ);
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick[i]) begin
        bus.mem_addr  = bus.req_addr[i*AW +: AW];
        bus.mem_wdata = bus.req_wdata[i*DW +: DW];
        bus.mem_ren   = ~bus.req_wr[i];
        bus.mem_wren  = bus.req_wr[i];
      end
    end
    bus.gnt = pick[N_REQ-1:0];
  end

  assign gnt_idx  = onehot2idx(pick);
  assign any_gnt  = |pick;
  assign lock_sel = |(pick & lock_v);
  assign tag_in   = {any_gnt & ~(|(pick & wr_v)), gnt_idx};

  // Lock FSM, round-robin pointer and read-data capture.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    rr_ptr_d     = rr_ptr_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (any_gnt && lock_sel) begin
          state_d      = ST_LOCKED;
          lock_owner_d = gnt_idx;
        end
      end
      ST_LOCKED: begin
        if (lock_eff) begin
          if (!lock_sel) state_d = ST_UNLOCKED;
        end else if (any_gnt && lock_sel) begin
          lock_owner_d = gnt_idx;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase
    // Pointer holds through a burst and moves on the releasing grant.
    if (any_gnt && !(lock_eff && lock_sel)) begin
      rr_ptr_d = (32'(gnt_idx) + 1 >= N_REQ) ? req_idx_t'(0) : req_idx_t'(gnt_idx + 1'b1);
    end
    if (tag_next.valid) rdata_d = bus.mem_q;
  end

  dmem_rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_in     (tag_in),
    .tag_next_c (tag_next),
    .tag_out    (tag_out)
  );

  always_comb begin
    bus.rvalid = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (tag_out.valid && (tag_out.idx == req_idx_t'(i))) bus.rvalid[i] = 1'b1;
    end
  end

  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: fixed-priority instance (RD_LAT=2) and round-robin instance (RD_LAT=3),
// with a scoreboard of expected read returns checked every cycle.
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) if_fix ();
  dmem_port_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) if_rr ();

  dmem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .RD_LAT(2), .ARB_MODE(0)) dut_fix (
    .clk(clk), .rst(rst), .bus(if_fix.slave));
  dmem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .RD_LAT(3), .ARB_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .bus(if_rr.slave));

  // RAM models: q valid RD_LAT-1 cycles after the granted access.
  logic [15:0] ram_f [1024];
  logic [15:0] ram_r [1024];
  logic [15:0] q_f, q_r1, q_r2;
  always @(posedge clk) begin
    if (if_fix.mem_wren) ram_f[if_fix.mem_addr[9:0]] <= if_fix.mem_wdata;
    q_f <= ram_f[if_fix.mem_addr[9:0]];
    if (if_rr.mem_wren) ram_r[if_rr.mem_addr[9:0]] <= if_rr.mem_wdata;
    q_r1 <= ram_r[if_rr.mem_addr[9:0]];
    q_r2 <= q_r1;
  end
  assign if_fix.mem_q = q_f;
  assign if_rr.mem_q  = q_r2;

  typedef struct {
    int unsigned due;
    logic [2:0]  idx;
    logic [15:0] data;
  } sb_t;
  sb_t sb_f[$];
  sb_t sb_r[$];

  int unsigned vec  = 0;
  int unsigned miss = 0;
  int unsigned cyc  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ret_check();
    logic [2:0] ev;
    ev = '0;
    if (sb_f.size() > 0 && sb_f[0].due == cyc) begin
      ev = 3'b001 << sb_f[0].idx;
      chk("rdata_fix", 32'(if_fix.rdata), 32'(sb_f[0].data));
      void'(sb_f.pop_front());
    end
    chk("rvalid_fix", 32'(if_fix.rvalid), 32'(ev));
    ev = '0;
    if (sb_r.size() > 0 && sb_r[0].due == cyc) begin
      ev = 3'b001 << sb_r[0].idx;
      chk("rdata_rr", 32'(if_rr.rdata), 32'(sb_r[0].data));
      void'(sb_r.pop_front());
    end
    chk("rvalid_rr", 32'(if_rr.rvalid), 32'(ev));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    ret_check();
  endtask

  task automatic set_addr(input bit rr, input int i, input logic [15:0] a, input logic [15:0] d);
    if (rr) begin
      if_rr.req_addr[i*16 +: 16]  = a;
      if_rr.req_wdata[i*16 +: 16] = d;
    end else begin
      if_fix.req_addr[i*16 +: 16]  = a;
      if_fix.req_wdata[i*16 +: 16] = d;
    end
  endtask

  task automatic drive(input bit rr, input logic [2:0] rq, input logic [2:0] wr, input logic [2:0] lk);
    if (rr) begin
      if_rr.req = rq; if_rr.req_wr = wr; if_rr.req_lock = lk;
    end else begin
      if_fix.req = rq; if_fix.req_wr = wr; if_fix.req_lock = lk;
    end
    #1;
  endtask

  // Check this cycle's grant, log an expected return for a granted read, then clock.
  task automatic gstep(input bit rr, input string tag, input logic [2:0] eg, input logic [15:0] ed);
    logic [2:0] wr;
    sb_t        e;
    wr = rr ? if_rr.req_wr : if_fix.req_wr;
    chk(tag, 32'(rr ? if_rr.gnt : if_fix.gnt), 32'(eg));
    if (eg != 3'b000 && (eg & wr) == 3'b000) begin
      e.idx  = (eg == 3'b001) ? 3'd0 : (eg == 3'b010) ? 3'd1 : 3'd2;
      e.data = ed;
      e.due  = cyc + (rr ? 3 : 2);
      if (rr) sb_r.push_back(e);
      else sb_f.push_back(e);
    end
    tick();
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt_fix"}, 32'(if_fix.gnt), 0);
    chk({tag, "_ren_fix"}, 32'(if_fix.mem_ren), 0);
    chk({tag, "_wren_fix"}, 32'(if_fix.mem_wren), 0);
    chk({tag, "_addr_fix"}, 32'(if_fix.mem_addr), 0);
    chk({tag, "_rvalid_fix"}, 32'(if_fix.rvalid), 0);
    chk({tag, "_rdata_fix"}, 32'(if_fix.rdata), 0);
    chk({tag, "_gnt_rr"}, 32'(if_rr.gnt), 0);
    chk({tag, "_ren_rr"}, 32'(if_rr.mem_ren), 0);
    chk({tag, "_rvalid_rr"}, 32'(if_rr.rvalid), 0);
    chk({tag, "_rdata_rr"}, 32'(if_rr.rdata), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_fix.req_addr = '0; if_fix.req_wdata = '0;
    if_rr.req_addr  = '0; if_rr.req_wdata  = '0;
    drive(0, 3'b111, 3'b000, 3'b000);
    drive(1, 3'b111, 3'b000, 3'b000);
    chk_quiet("reset");
    tick(); tick();
    rst = 1'b0;
    drive(0, 3'b000, 3'b000, 3'b000);
    drive(1, 3'b000, 3'b000, 3'b000);

    // Preload RAM through the port
    set_addr(0, 0, 16'h0010, 16'hAAAA);
    drive(0, 3'b001, 3'b001, 3'b000);
    chk("pre_wren", 32'(if_fix.mem_wren), 1);
    gstep(0, "pre_wr0", 3'b001, 16'h0);
    set_addr(0, 0, 16'h0011, 16'hBBBB);
    gstep(0, "pre_wr1", 3'b001, 16'h0);

    // Fixed priority: req1 starves req2 until it drops
    set_addr(0, 1, 16'h0020, 16'h0101);
    set_addr(0, 2, 16'h0021, 16'h0202);
    drive(0, 3'b110, 3'b110, 3'b000);
    repeat (3) gstep(0, "fix_gnt1", 3'b010, 16'h0);
    drive(0, 3'b100, 3'b100, 3'b000);
    gstep(0, "fix_gnt2", 3'b100, 16'h0);

    // Back-to-back reads from different requesters
    set_addr(0, 0, 16'h0010, 16'h0);
    drive(0, 3'b001, 3'b000, 3'b000);
    chk("rd_addr", 32'(if_fix.mem_addr), 32'h0010);
    chk("rd_ren", 32'(if_fix.mem_ren), 1);
    gstep(0, "rd_gnt0", 3'b001, 16'hAAAA);
    set_addr(0, 2, 16'h0011, 16'h0);
    drive(0, 3'b100, 3'b000, 3'b000);
    gstep(0, "rd_gnt2", 3'b100, 16'hBBBB);
    drive(0, 3'b000, 3'b000, 3'b000);
    repeat (3) gstep(0, "rd_idle", 3'b000, 16'h0);

    // Write then read-back by another requester
    set_addr(0, 0, 16'h0005, 16'h1234);
    drive(0, 3'b001, 3'b001, 3'b000);
    chk("wr_wdata", 32'(if_fix.mem_wdata), 32'h1234);
    chk("wr_ren", 32'(if_fix.mem_ren), 0);
    gstep(0, "wr_gnt0", 3'b001, 16'h0);
    set_addr(0, 1, 16'h0005, 16'h0);
    drive(0, 3'b010, 3'b000, 3'b000);
    gstep(0, "rb_gnt1", 3'b010, 16'h1234);
    drive(0, 3'b000, 3'b000, 3'b000);
    repeat (3) gstep(0, "rb_idle", 3'b000, 16'h0);

    // Locked burst holds off higher-priority req0
    set_addr(0, 0, 16'h0030, 16'h3333);
    set_addr(0, 1, 16'h0100, 16'hC000);
    drive(0, 3'b010, 3'b010, 3'b010);
    gstep(0, "lk_gnt_a", 3'b010, 16'h0);
    set_addr(0, 1, 16'h0101, 16'hC001);
    drive(0, 3'b011, 3'b011, 3'b010);
    gstep(0, "lk_gnt_b", 3'b010, 16'h0);
    set_addr(0, 1, 16'h0102, 16'hC002);
    #1;
    chk("lk_addr", 32'(if_fix.mem_addr), 32'h0102);
    gstep(0, "lk_gnt_c", 3'b010, 16'h0);
    set_addr(0, 1, 16'h0103, 16'hC003);
    drive(0, 3'b011, 3'b011, 3'b000);
    gstep(0, "lk_gnt_d", 3'b010, 16'h0);
    drive(0, 3'b001, 3'b001, 3'b000);
    gstep(0, "lk_release", 3'b001, 16'h0);

    // Lock released by the owner dropping req
    set_addr(0, 1, 16'h0104, 16'hC004);
    drive(0, 3'b010, 3'b010, 3'b010);
    gstep(0, "lk2_gnt", 3'b010, 16'h0);
    drive(0, 3'b001, 3'b001, 3'b000);
    gstep(0, "lk2_drop", 3'b001, 16'h0);
    drive(0, 3'b000, 3'b000, 3'b000);
    gstep(0, "lk2_idle", 3'b000, 16'h0);

    // Round-robin rotation
    for (int i = 0; i < 3; i++) set_addr(1, i, 16'(16'h0050 + i), 16'(16'h5000 + i));
    drive(1, 3'b111, 3'b111, 3'b000);
    repeat (2) begin
      gstep(1, "rr_gnt0", 3'b001, 16'h0);
      gstep(1, "rr_gnt1", 3'b010, 16'h0);
      gstep(1, "rr_gnt2", 3'b100, 16'h0);
    end

    // Reset with a read in flight
    set_addr(1, 0, 16'h0040, 16'h0);
    drive(1, 3'b001, 3'b000, 3'b000);
    gstep(1, "mr_gnt0", 3'b001, 16'h0);
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    sb_f.delete();
    sb_r.delete();
    tick(); tick();
    rst = 1'b0;
    drive(1, 3'b000, 3'b000, 3'b000);
    repeat (5) tick();

    chk("sb_left_fix", 32'(sb_f.size()), 0);
    chk("sb_left_rr", 32'(sb_r.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
